// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder family: default operand width and reset value.
package full_adder_pkg;

    localparam int unsigned FA_WIDTH_DEF = 1;
    localparam logic        FA_RST_VAL   = 1'b0;

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full-adder cell; one link of the ripple-carry chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder {c_out,sum} = a + b + c_in with optional output register.
// Optional signed-overflow output enabled by defining FULL_ADDER_OVF_EN.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH   = FA_WIDTH_DEF,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
`ifdef FULL_ADDER_OVF_EN
    output logic             c_out,
    output logic             ovf
`else
    output logic             c_out
`endif
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    assign carry[0] = c_in;

    // Ripple chain: bit i consumes carry[i] and produces carry[i+1].
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_c[i]),
            .co (carry[i+1])
        );
    end

`ifdef FULL_ADDER_OVF_EN
    logic ovf_c;

    // Two's-complement overflow: carry into and out of the sign bit disagree.
    assign ovf_c = carry[WIDTH] ^ carry[WIDTH-1];
`endif

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             c_out_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= {WIDTH{FA_RST_VAL}};
                c_out_q <= FA_RST_VAL;
            end else begin
                sum_q   <= sum_c;
                c_out_q <= carry[WIDTH];
            end
        end

        assign sum   = sum_q;
        assign c_out = c_out_q;

`ifdef FULL_ADDER_OVF_EN
        logic ovf_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ovf_q <= FA_RST_VAL;
            end else begin
                ovf_q <= ovf_c;
            end
        end

        assign ovf = ovf_q;
`endif
    end else begin : g_comb
        assign sum   = sum_c;
        assign c_out = carry[WIDTH];
`ifdef FULL_ADDER_OVF_EN
        assign ovf   = ovf_c;
`endif
    end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder: WIDTH=1 and WIDTH=8 registered, WIDTH=8 combinational.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       a1, b1, c1;
    logic       s1, co1;
    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] s8, sc8;
    logic       co8, coc8;
`ifdef FULL_ADDER_OVF_EN
    logic       ov1, ov8, ovc8;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec8_t;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1),
        .b     (b1),
        .c_in  (c1),
        .sum   (s1),
`ifdef FULL_ADDER_OVF_EN
        .c_out (co1),
        .ovf   (ov1)
`else
        .c_out (co1)
`endif
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .c_in  (c8),
        .sum   (s8),
`ifdef FULL_ADDER_OVF_EN
        .c_out (co8),
        .ovf   (ov8)
`else
        .c_out (co8)
`endif
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b0)) dutc (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .c_in  (c8),
        .sum   (sc8),
`ifdef FULL_ADDER_OVF_EN
        .c_out (coc8),
        .ovf   (ovc8)
`else
        .c_out (coc8)
`endif
    );

    task automatic test_reset();
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({co1, s1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_w1: got {c_out,sum}=%b expected 00", {co1, s1});
        end
        checks++;
        if ({co8, s8} !== 9'h000) begin
            errors++;
            $display("FAIL reset_w8: got {c_out,sum}=%h expected 000", {co8, s8});
        end
`ifdef FULL_ADDER_OVF_EN
        checks++;
        if ({ov1, ov8} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ovf: got ovf1,ovf8=%b expected 00", {ov1, ov8});
        end
`endif
    endtask

    task automatic test_release();
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({co1, s1} !== 2'b00) begin
            errors++;
            $display("FAIL release_000: got %b expected 00", {co1, s1});
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({co1, s1} !== 2'b01) begin
            errors++;
            $display("FAIL basic_001: got %b expected 01", {co1, s1});
        end
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        // Result must not appear before the capturing edge.
        checks++;
        if ({co1, s1} !== 2'b01) begin
            errors++;
            $display("FAIL latency_hold: got %b expected 01", {co1, s1});
        end
        @(posedge clk); #1;
        checks++;
        if ({co1, s1} !== 2'b10) begin
            errors++;
            $display("FAIL basic_110: got %b expected 10", {co1, s1});
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] in_tab [5]  = '{3'b111, 3'b010, 3'b101, 3'b000, 3'b011};
        logic [1:0] exp_tab [5] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b10};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            {a1, b1, c1} = in_tab[i];
            @(posedge clk); #1;
            checks++;
            if ({co1, s1} !== exp_tab[i]) begin
                errors++;
                $display("FAIL b2b_%0d: in=%b got %b expected %b", i, in_tab[i], {co1, s1}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_exhaustive_w1();
        logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            {a1, b1, c1} = v;
            @(posedge clk); #1;
            checks++;
            if ({co1, s1} !== exp_tab[i]) begin
                errors++;
                $display("FAIL exh_w1_%b: got %b expected %b", v, {co1, s1}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_width8();
        vec8_t v [8];
        v[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        v[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        v[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        v[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        v[4] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        v[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        v[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        v[7] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a8 = v[i].a; b8 = v[i].b; c8 = v[i].ci;
            #1;
            checks++;
            if ({coc8, sc8} !== {v[i].co, v[i].s}) begin
                errors++;
                $display("FAIL comb_w8_%0d: got %h expected %h", i, {coc8, sc8}, {v[i].co, v[i].s});
            end
            @(posedge clk); #1;
            checks++;
            if ({co8, s8} !== {v[i].co, v[i].s}) begin
                errors++;
                $display("FAIL reg_w8_%0d: %h+%h+%b got %h expected %h", i, v[i].a, v[i].b, v[i].ci,
                         {co8, s8}, {v[i].co, v[i].s});
            end
`ifdef FULL_ADDER_OVF_EN
            checks++;
            if ({ov8, ovc8} !== {2{v[i].ov}}) begin
                errors++;
                $display("FAIL ovf_w8_%0d: got reg=%b comb=%b expected %b", i, ov8, ovc8, v[i].ov);
            end
`endif
        end
    endtask

    task automatic test_random_w8();
        logic [8:0] exp_r;
        logic       exp_ov;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
            exp_r  = 9'(a8) + 9'(b8) + 9'(c8);
            exp_ov = (a8[7] == b8[7]) && (exp_r[7] != a8[7]);
            @(posedge clk); #1;
            checks++;
            if ({co8, s8} !== exp_r) begin
                errors++;
                $display("FAIL rand_w8_%0d: got %h expected %h", i, {co8, s8}, exp_r);
            end
`ifdef FULL_ADDER_OVF_EN
            checks++;
            if (ov8 !== exp_ov) begin
                errors++;
                $display("FAIL rand_ovf_%0d: got %b expected %b", i, ov8, exp_ov);
            end
`else
            exp_ov = 1'b0;
`endif
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({co8, s8, co1, s1} !== {9'h100, 2'b11}) begin
            errors++;
            $display("FAIL pre_reset: got %h expected %h", {co8, s8, co1, s1}, {9'h100, 2'b11});
        end
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({co8, s8, co1, s1} !== 11'h000) begin
            errors++;
            $display("FAIL mid_reset_async: got %h expected 000", {co8, s8, co1, s1});
        end
        @(posedge clk); #1;
        checks++;
        if ({co8, s8, co1, s1} !== 11'h000) begin
            errors++;
            $display("FAIL mid_reset_hold: got %h expected 000", {co8, s8, co1, s1});
        end
`ifdef FULL_ADDER_OVF_EN
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ovf: got %b expected 0", ov8);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({co8, s8} !== 9'h047) begin
            errors++;
            $display("FAIL post_reset: got %h expected 047", {co8, s8});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_release();
        test_basic();
        test_back_to_back();
        test_exhaustive_w1();
        test_width8();
        test_random_w8();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_full_adder
